// File: rtl/l2_p_pkg.sv
// Shared types for the L2 memory power sequencer: sequencer states and
// the low-power flavour latched on entry.
package l2_p_pkg;

  typedef enum logic [2:0] {
    ACTIVE,
    DRAIN,
    SETTLE,
    LOWPWR,
    WAKE
  } l2_pwr_state_e;

  typedef enum logic {
    MODE_RET,
    MODE_PDE
  } l2_pwr_mode_e;

endpackage

// File: rtl/l2_pwr_gate.sv
// One AXI address channel gate: valid/ready pass-through when open, a pending
// flag so a presented valid is never withdrawn, and a saturating in-flight counter.
module l2_pwr_gate #(
  parameter int MaxOutstanding = 64,
  localparam int CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_open,
  input  logic i_s_valid,
  output logic o_s_ready,
  output logic o_m_valid,
  input  logic i_m_ready,
  input  logic i_dec,
  output logic o_idle,
  output logic o_err
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt;
  logic            pending;
  logic            pass;
  logic            inc;

  // A valid already shown to the memory core keeps the channel open until it is taken.
  assign pass      = (i_open && (cnt != CntMax)) || pending;
  assign o_m_valid = pass & i_s_valid;
  assign o_s_ready = pass & i_m_ready;
  assign inc       = o_m_valid & i_m_ready;
  assign o_idle    = (cnt == '0) && !pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      pending <= o_m_valid & ~i_m_ready;
      if (inc && !i_dec) begin
        if (cnt == CntMax) o_err <= 1'b1;
        else               cnt   <= cnt + 1'b1;
      end else if (!inc && i_dec) begin
        if (cnt == '0) o_err <= 1'b1;
        else           cnt   <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_mem_pwr_seq.sv
// L2 partition SRAM low-power sequencer: blocks and drains AXI address traffic,
// then walks the macros into retention or power-down and back out again.
module l2_mem_pwr_seq
  import l2_p_pkg::*;
#(
  parameter int MaxOutstanding = 64,
  parameter int SettleCycles   = 16,
  localparam int SetW = $clog2(SettleCycles + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ret_req,
  input  logic i_pde_req,
  output logic o_ret,
  output logic o_pde,
  input  logic i_prn,
  output logic o_prn,
  output logic o_lp_ack,
  output logic o_err,
  input  logic i_axi_s_aw_valid,
  output logic o_axi_s_aw_ready,
  output logic o_axi_m_aw_valid,
  input  logic i_axi_m_aw_ready,
  input  logic i_axi_s_ar_valid,
  output logic o_axi_s_ar_ready,
  output logic o_axi_m_ar_valid,
  input  logic i_axi_m_ar_ready,
  input  logic i_axi_b_hs,
  input  logic i_axi_r_last_hs
);

  localparam logic [SetW-1:0] SettleLoad = SetW'(SettleCycles);

  l2_pwr_state_e   state_q, state_nxt;
  l2_pwr_mode_e    mode_q, mode_nxt;
  logic [SetW-1:0] set_cnt_q, set_cnt_nxt;
  logic            ret_nxt, pde_nxt;
  logic            wr_idle, rd_idle, wr_err, rd_err;
  logic            req;
  l2_pwr_mode_e    req_mode;

  assign req      = i_ret_req | i_pde_req;
  assign req_mode = i_pde_req ? MODE_PDE : MODE_RET;
  assign o_lp_ack = (state_q == LOWPWR);
  assign o_err    = wr_err | rd_err;

  l2_pwr_gate #(.MaxOutstanding(MaxOutstanding)) u_aw_gate (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_open    (state_q == ACTIVE),
    .i_s_valid (i_axi_s_aw_valid),
    .o_s_ready (o_axi_s_aw_ready),
    .o_m_valid (o_axi_m_aw_valid),
    .i_m_ready (i_axi_m_aw_ready),
    .i_dec     (i_axi_b_hs),
    .o_idle    (wr_idle),
    .o_err     (wr_err)
  );

  l2_pwr_gate #(.MaxOutstanding(MaxOutstanding)) u_ar_gate (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_open    (state_q == ACTIVE),
    .i_s_valid (i_axi_s_ar_valid),
    .o_s_ready (o_axi_s_ar_ready),
    .o_m_valid (o_axi_m_ar_valid),
    .i_m_ready (i_axi_m_ar_ready),
    .i_dec     (i_axi_r_last_hs),
    .o_idle    (rd_idle),
    .o_err     (rd_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ACTIVE;
      mode_q    <= MODE_RET;
      set_cnt_q <= '0;
      o_ret     <= 1'b0;
      o_pde     <= 1'b0;
      o_prn     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      mode_q    <= mode_nxt;
      set_cnt_q <= set_cnt_nxt;
      o_ret     <= ret_nxt;
      o_pde     <= pde_nxt;
      o_prn     <= i_prn;
    end
  end

  // Once ret/pde is driven the entry runs to LOWPWR regardless of the request level.
  always_comb begin
    state_nxt   = state_q;
    mode_nxt    = mode_q;
    set_cnt_nxt = set_cnt_q;
    ret_nxt     = o_ret;
    pde_nxt     = o_pde;
    unique case (state_q)
      ACTIVE: begin
        if (req) begin
          state_nxt = DRAIN;
          mode_nxt  = req_mode;
        end
      end
      DRAIN: begin
        if (!req) begin
          state_nxt = ACTIVE;
        end else if (wr_idle && rd_idle) begin
          state_nxt   = SETTLE;
          set_cnt_nxt = SettleLoad;
          if (mode_q == MODE_PDE) pde_nxt = 1'b1;
          else                    ret_nxt = 1'b1;
        end
      end
      SETTLE: begin
        if (set_cnt_q != '0) begin
          set_cnt_nxt = set_cnt_q - 1'b1;
        end else if ((mode_q == MODE_RET) || i_prn) begin
          state_nxt = LOWPWR;
        end
      end
      LOWPWR: begin
        if (!req || (req_mode != mode_q)) begin
          state_nxt   = WAKE;
          ret_nxt     = 1'b0;
          pde_nxt     = 1'b0;
          set_cnt_nxt = SettleLoad;
        end
      end
      WAKE: begin
        if (set_cnt_q != '0) begin
          set_cnt_nxt = set_cnt_q - 1'b1;
        end else if ((mode_q == MODE_RET) || !i_prn) begin
          state_nxt = ACTIVE;
        end
      end
      default: state_nxt = ACTIVE;
    endcase
  end

endmodule

// File: tb/tb_l2_mem_pwr_seq.sv
// Directed and randomized bench for l2_mem_pwr_seq; expected values come from
// in-flight counts kept here and the settle/prn timing rules of the sequencer.
module tb_l2_mem_pwr_seq;

  localparam int Settle = 16;
  localparam int MaxOut = 64;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_ret_req, i_pde_req, i_prn;
  logic o_ret, o_pde, o_prn, o_lp_ack, o_err;
  logic i_axi_s_aw_valid, o_axi_s_aw_ready, o_axi_m_aw_valid, i_axi_m_aw_ready;
  logic i_axi_s_ar_valid, o_axi_s_ar_ready, o_axi_m_ar_valid, i_axi_m_ar_ready;
  logic i_axi_b_hs, i_axi_r_last_hs;

  int errors = 0;
  int checks = 0;
  int wr_out = 0;
  int rd_out = 0;
  logic awv, awr, arv, arr, bh, rh, aw_hold, ar_hold;

  always #5 i_clk = ~i_clk;

  l2_mem_pwr_seq dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_ret_req        (i_ret_req),
    .i_pde_req        (i_pde_req),
    .o_ret            (o_ret),
    .o_pde            (o_pde),
    .i_prn            (i_prn),
    .o_prn            (o_prn),
    .o_lp_ack         (o_lp_ack),
    .o_err            (o_err),
    .i_axi_s_aw_valid (i_axi_s_aw_valid),
    .o_axi_s_aw_ready (o_axi_s_aw_ready),
    .o_axi_m_aw_valid (o_axi_m_aw_valid),
    .i_axi_m_aw_ready (i_axi_m_aw_ready),
    .i_axi_s_ar_valid (i_axi_s_ar_valid),
    .o_axi_s_ar_ready (o_axi_s_ar_ready),
    .o_axi_m_ar_valid (o_axi_m_ar_valid),
    .i_axi_m_ar_ready (i_axi_m_ar_ready),
    .i_axi_b_hs       (i_axi_b_hs),
    .i_axi_r_last_hs  (i_axi_r_last_hs)
  );

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic aw_v, input logic aw_r, input logic ar_v,
                                input logic ar_r, input logic b, input logic r);
    i_axi_s_aw_valid = aw_v;
    i_axi_m_aw_ready = aw_r;
    i_axi_s_ar_valid = ar_v;
    i_axi_m_ar_ready = ar_r;
    i_axi_b_hs       = b;
    i_axi_r_last_hs  = r;
    #1;
  endtask

  // Return every outstanding response one per cycle, keeping the given address valids.
  task automatic drain_responses(input logic hold_v, input logic gated);
    while (wr_out > 0 || rd_out > 0) begin
      bh = (wr_out > 0);
      rh = (rd_out > 0);
      apply_stimulus(hold_v, 1'b1, hold_v, 1'b1, bh, rh);
      if (gated) begin
        check_output("drain_aw_blocked", o_axi_m_aw_valid, 1'b0);
        check_output("drain_ar_blocked", o_axi_m_ar_valid, 1'b0);
        check_output("drain_no_ret", o_ret | o_pde, 1'b0);
      end
      tick();
      if (bh) wr_out--;
      if (rh) rd_out--;
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_ret_req = 1'b0;
    i_pde_req = 1'b0;
    i_prn = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("rst_ret", o_ret, 1'b0);
    check_output("rst_pde", o_pde, 1'b0);
    check_output("rst_prn", o_prn, 1'b0);
    check_output("rst_lp_ack", o_lp_ack, 1'b0);
    check_output("rst_err", o_err, 1'b0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    $display("[TB] random traffic in ACTIVE");
    aw_hold = 1'b0;
    ar_hold = 1'b0;
    for (int i = 0; i < 150; i++) begin
      awv = aw_hold ? 1'b1 : ((wr_out < 40) ? 1'($urandom_range(0, 1)) : 1'b0);
      arv = ar_hold ? 1'b1 : ((rd_out < 40) ? 1'($urandom_range(0, 1)) : 1'b0);
      awr = 1'($urandom_range(0, 1));
      arr = 1'($urandom_range(0, 1));
      bh  = (wr_out > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rh  = (rd_out > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      apply_stimulus(awv, awr, arv, arr, bh, rh);
      check_output("act_aw_valid", o_axi_m_aw_valid, awv);
      check_output("act_aw_ready", o_axi_s_aw_ready, awr);
      check_output("act_ar_valid", o_axi_m_ar_valid, arv);
      check_output("act_ar_ready", o_axi_s_ar_ready, arr);
      tick();
      if (awv && awr) wr_out++;
      if (arv && arr) rd_out++;
      if (bh) wr_out--;
      if (rh) rd_out--;
      aw_hold = awv && !awr;
      ar_hold = arv && !arr;
    end
    apply_stimulus(aw_hold, 1, ar_hold, 1, 0, 0);
    tick();
    if (aw_hold) wr_out++;
    if (ar_hold) rd_out++;
    check_output("act_no_err", o_err, 1'b0);

    $display("[TB] retention entry after draining");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 1, 0, 0, 0, 0);
      tick();
      wr_out++;
    end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 0, 0, 0, 1, 0);
      tick();
      wr_out--;
    end
    i_ret_req = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick();
    drain_responses(1'b1, 1'b1);
    apply_stimulus(1, 1, 1, 1, 0, 0);
    check_output("ret_before_settle", o_ret, 1'b0);
    tick();
    check_output("ret_on", o_ret, 1'b1);
    check_output("ret_no_pde", o_pde, 1'b0);
    for (int k = 0; k <= Settle; k++) begin
      check_output("ret_settle_no_ack", o_lp_ack, 1'b0);
      check_output("ret_settle_aw_blocked", o_axi_m_aw_valid, 1'b0);
      check_output("ret_settle_ar_blocked", o_axi_m_ar_valid, 1'b0);
      tick();
    end
    check_output("ret_lp_ack", o_lp_ack, 1'b1);
    i_ret_req = 1'b0;
    #1;
    tick();
    check_output("ret_wake_ret_off", o_ret, 1'b0);
    check_output("ret_wake_ack_off", o_lp_ack, 1'b0);
    for (int k = 0; k <= Settle; k++) begin
      check_output("ret_wake_aw_blocked", o_axi_m_aw_valid, 1'b0);
      tick();
    end
    check_output("ret_resume_aw", o_axi_m_aw_valid, 1'b1);
    check_output("ret_resume_ar", o_axi_m_ar_valid, 1'b1);
    tick();
    wr_out++;
    rd_out++;
    apply_stimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] power-down entry with a pending AW");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    tick();
    i_pde_req = 1'b1;
    #1;
    check_output("pde_pend_active", o_axi_m_aw_valid, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check_output("pde_pend_hold", o_axi_m_aw_valid, 1'b1);
      tick();
    end
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_output("pde_pend_accept_v", o_axi_m_aw_valid, 1'b1);
    check_output("pde_pend_accept_r", o_axi_s_aw_ready, 1'b1);
    tick();
    wr_out++;
    apply_stimulus(0, 1, 0, 1, 0, 0);
    check_output("pde_closed_after_pend", o_axi_s_aw_ready, 1'b0);
    drain_responses(1'b0, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick();
    check_output("pde_on", o_pde, 1'b1);
    check_output("pde_no_ret", o_ret, 1'b0);
    for (int k = 0; k < 40; k++) begin
      check_output("pde_wait_prn_no_ack", o_lp_ack, 1'b0);
      check_output("pde_wait_prn_low", o_prn, 1'b0);
      tick();
    end
    i_prn = 1'b1;
    #1;
    check_output("pde_prn_seen_no_ack", o_lp_ack, 1'b0);
    tick();
    check_output("pde_lp_ack", o_lp_ack, 1'b1);
    check_output("pde_prn_out", o_prn, 1'b1);
    i_pde_req = 1'b0;
    #1;
    tick();
    check_output("pde_exit_off", o_pde, 1'b0);
    check_output("pde_exit_ack_off", o_lp_ack, 1'b0);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 25; k++) begin
      check_output("pde_wake_wait_prn", o_axi_m_aw_valid, 1'b0);
      tick();
    end
    i_prn = 1'b0;
    #1;
    check_output("pde_wake_last_blocked", o_axi_m_aw_valid, 1'b0);
    tick();
    check_output("pde_resume_aw", o_axi_m_aw_valid, 1'b1);
    check_output("pde_resume_prn_low", o_prn, 1'b0);
    tick();
    wr_out++;
    apply_stimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] aborted retention request");
    drain_responses(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 1, 0, 0, 0, 0);
      tick();
      wr_out++;
    end
    apply_stimulus(0, 1, 0, 0, 0, 0);
    i_ret_req = 1'b1;
    tick();
    check_output("abort_drain_closed", o_axi_s_aw_ready, 1'b0);
    tick();
    i_ret_req = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      check_output("abort_no_ret", o_ret, 1'b0);
      check_output("abort_open", o_axi_s_aw_ready, 1'b1);
      tick();
    end
    drain_responses(1'b0, 1'b0);

    $display("[TB] outstanding limit and counter error");
    for (int i = 0; i < MaxOut; i++) begin
      apply_stimulus(1, 1, 0, 0, 0, 0);
      if (i == 0 || i == MaxOut - 1) check_output("fill_ready", o_axi_s_aw_ready, 1'b1);
      tick();
      wr_out++;
    end
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_output("full_stall_ready", o_axi_s_aw_ready, 1'b0);
    check_output("full_stall_valid", o_axi_m_aw_valid, 1'b0);
    apply_stimulus(1, 1, 0, 0, 1, 0);
    check_output("full_stall_with_b", o_axi_s_aw_ready, 1'b0);
    tick();
    wr_out--;
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_output("full_reopen", o_axi_m_aw_valid, 1'b1);
    tick();
    wr_out++;
    check_output("full_no_err", o_err, 1'b0);
    drain_responses(1'b0, 1'b0);
    check_output("empty_no_err", o_err, 1'b0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("underflow_err", o_err, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    check_output("err_sticky", o_err, 1'b1);

    $display("[TB] async reset during SETTLE");
    i_ret_req = 1'b1;
    i_pde_req = 1'b1;
    tick();
    tick();
    check_output("both_pde_wins", o_pde, 1'b1);
    check_output("both_no_ret", o_ret, 1'b0);
    tick();
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check_output("arst_pde", o_pde, 1'b0);
    check_output("arst_ret", o_ret, 1'b0);
    check_output("arst_ack", o_lp_ack, 1'b0);
    check_output("arst_err", o_err, 1'b0);
    i_ret_req = 1'b0;
    i_pde_req = 1'b0;
    tick();
    #2;
    i_rst_n = 1'b1;
    tick();
    apply_stimulus(0, 1, 0, 1, 0, 0);
    check_output("arst_active_aw", o_axi_s_aw_ready, 1'b1);
    check_output("arst_active_ar", o_axi_s_ar_ready, 1'b1);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("arst_rd_cnt_zero", o_err, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
